// File: rtl/sodor5_wb_checker.sv
// sodor5_wb_checker
//
// Consumer side of the sodor5 instruction-stream bench. The block collects register
// writebacks from the reference model and from the RTL core, keeps each stream in its
// own FIFO, and compares the heads pairwise in retirement order. On the first
// divergence, overflow or timeout it latches a cause and halts.
//
// Parameters:
//   XLEN    - register data width
//   DEPTH   - entries per FIFO (power of two, >= 2)
//   TIMEOUT - cycles one FIFO may stay non-empty while the other is empty (>= 1)
//
// Ports:
//   clk_i            clock, all state updates on posedge
//   reset_ni         asynchronous active-low reset
//   ref_wb_valid_i   model writeback event this cycle
//   ref_wb_rd_i      model destination register
//   ref_wb_data_i    model writeback value
//   dut_wb_valid_i   core writeback event this cycle
//   dut_wb_rd_i      core destination register
//   dut_wb_data_i    core writeback value
//   match_count_o    number of compared pairs that matched (wraps)
//   fail_o           sticky, high once the checker has halted
//   fail_cause_o     0 none, 1 mismatch, 2 overflow, 3 timeout
//   err_ref_rd_o     rd of the first mismatching model entry
//   err_dut_rd_o     rd of the first mismatching core entry
//   err_ref_data_o   data of the first mismatching model entry
//   err_dut_data_o   data of the first mismatching core entry
module sodor5_wb_checker #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            ref_wb_valid_i,
  input  logic [4:0]      ref_wb_rd_i,
  input  logic [XLEN-1:0] ref_wb_data_i,
  input  logic            dut_wb_valid_i,
  input  logic [4:0]      dut_wb_rd_i,
  input  logic [XLEN-1:0] dut_wb_data_i,
  output logic [31:0]     match_count_o,
  output logic            fail_o,
  output logic [1:0]      fail_cause_o,
  output logic [4:0]      err_ref_rd_o,
  output logic [4:0]      err_dut_rd_o,
  output logic [XLEN-1:0] err_ref_data_o,
  output logic [XLEN-1:0] err_dut_data_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = 5 + XLEN;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLast = TW'(TIMEOUT - 1);

  localparam logic [1:0] CauseNone     = 2'd0;
  localparam logic [1:0] CauseMismatch = 2'd1;
  localparam logic [1:0] CauseOverflow = 2'd2;
  localparam logic [1:0] CauseTimeout  = 2'd3;

  typedef enum logic [0:0] {StRun, StFail} state_e;

  state_e state_q, state_d;

  // FIFO storage; pointers carry one extra bit so full and empty are distinct.
  logic [EW-1:0] ref_mem_q [DEPTH];
  logic [EW-1:0] dut_mem_q [DEPTH];
  logic [AW:0]   ref_wptr_q, ref_wptr_d, ref_rptr_q, ref_rptr_d;
  logic [AW:0]   dut_wptr_q, dut_wptr_d, dut_rptr_q, dut_rptr_d;

  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [31:0]     match_q, match_d;
  logic            fail_q, fail_d;
  logic [1:0]      cause_q, cause_d;
  logic [4:0]      err_ref_rd_q, err_ref_rd_d, err_dut_rd_q, err_dut_rd_d;
  logic [XLEN-1:0] err_ref_data_q, err_ref_data_d, err_dut_data_q, err_dut_data_d;

  logic          run;
  logic          ref_empty, ref_full, dut_empty, dut_full;
  logic          ref_req, dut_req, ref_ovf, dut_ovf, ref_push, dut_push;
  logic          pop, mismatch, one_ne, to_hit;
  logic [EW-1:0] ref_head, dut_head;

  always_comb begin
    run       = (state_q == StRun);
    ref_empty = (ref_wptr_q == ref_rptr_q);
    dut_empty = (dut_wptr_q == dut_rptr_q);
    ref_full  = (ref_wptr_q[AW] != ref_rptr_q[AW]) &&
                (ref_wptr_q[AW-1:0] == ref_rptr_q[AW-1:0]);
    dut_full  = (dut_wptr_q[AW] != dut_rptr_q[AW]) &&
                (dut_wptr_q[AW-1:0] == dut_rptr_q[AW-1:0]);
    ref_head  = ref_mem_q[ref_rptr_q[AW-1:0]];
    dut_head  = dut_mem_q[dut_rptr_q[AW-1:0]];

    pop       = run && !ref_empty && !dut_empty;
    // Writes to x0 are architecturally invisible, so they never enter a FIFO.
    ref_req   = run && ref_wb_valid_i && (ref_wb_rd_i != 5'd0);
    dut_req   = run && dut_wb_valid_i && (dut_wb_rd_i != 5'd0);
    // A full FIFO can still accept a push when its head leaves on the same edge.
    ref_ovf   = ref_req && ref_full && !pop;
    dut_ovf   = dut_req && dut_full && !pop;
    ref_push  = ref_req && !ref_ovf;
    dut_push  = dut_req && !dut_ovf;

    mismatch  = pop && (ref_head != dut_head);
    one_ne    = (ref_empty != dut_empty);
    to_hit    = run && one_ne && (tcnt_q == TLast);
  end

  always_comb begin
    state_d        = state_q;
    ref_wptr_d     = ref_wptr_q + {{AW{1'b0}}, ref_push};
    dut_wptr_d     = dut_wptr_q + {{AW{1'b0}}, dut_push};
    ref_rptr_d     = ref_rptr_q + {{AW{1'b0}}, pop};
    dut_rptr_d     = dut_rptr_q + {{AW{1'b0}}, pop};
    tcnt_d         = tcnt_q;
    match_d        = match_q;
    cause_d        = cause_q;
    err_ref_rd_d   = err_ref_rd_q;
    err_dut_rd_d   = err_dut_rd_q;
    err_ref_data_d = err_ref_data_q;
    err_dut_data_d = err_dut_data_q;

    unique case (state_q)
      StRun: begin
        if (pop && !mismatch) begin
          match_d = match_q + 32'd1;
        end

        if (pop || (ref_empty && dut_empty)) begin
          tcnt_d = '0;
        end else if (one_ne) begin
          tcnt_d = tcnt_q + {{(TW-1){1'b0}}, 1'b1};
        end

        // Mismatch outranks overflow, which outranks timeout.
        if (mismatch) begin
          state_d        = StFail;
          cause_d        = CauseMismatch;
          err_ref_rd_d   = ref_head[EW-1 -: 5];
          err_dut_rd_d   = dut_head[EW-1 -: 5];
          err_ref_data_d = ref_head[XLEN-1:0];
          err_dut_data_d = dut_head[XLEN-1:0];
        end else if (ref_ovf || dut_ovf) begin
          state_d = StFail;
          cause_d = CauseOverflow;
        end else if (to_hit) begin
          state_d = StFail;
          cause_d = CauseTimeout;
        end
      end
      StFail: begin
        // Absorbing: nothing moves until reset.
        ref_wptr_d = ref_wptr_q;
        dut_wptr_d = dut_wptr_q;
        ref_rptr_d = ref_rptr_q;
        dut_rptr_d = dut_rptr_q;
      end
      default: begin
        state_d = StFail;
      end
    endcase

    fail_d = (cause_d != CauseNone);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q        <= StRun;
      ref_wptr_q     <= '0;
      ref_rptr_q     <= '0;
      dut_wptr_q     <= '0;
      dut_rptr_q     <= '0;
      tcnt_q         <= '0;
      match_q        <= '0;
      fail_q         <= 1'b0;
      cause_q        <= CauseNone;
      err_ref_rd_q   <= '0;
      err_dut_rd_q   <= '0;
      err_ref_data_q <= '0;
      err_dut_data_q <= '0;
    end else begin
      state_q        <= state_d;
      ref_wptr_q     <= ref_wptr_d;
      ref_rptr_q     <= ref_rptr_d;
      dut_wptr_q     <= dut_wptr_d;
      dut_rptr_q     <= dut_rptr_d;
      tcnt_q         <= tcnt_d;
      match_q        <= match_d;
      fail_q         <= fail_d;
      cause_q        <= cause_d;
      err_ref_rd_q   <= err_ref_rd_d;
      err_dut_rd_q   <= err_dut_rd_d;
      err_ref_data_q <= err_ref_data_d;
      err_dut_data_q <= err_dut_data_d;
    end
  end

  // Storage needs no reset: contents are only read between the pointers.
  always_ff @(posedge clk_i) begin
    if (ref_push) begin
      ref_mem_q[ref_wptr_q[AW-1:0]] <= {ref_wb_rd_i, ref_wb_data_i};
    end
    if (dut_push) begin
      dut_mem_q[dut_wptr_q[AW-1:0]] <= {dut_wb_rd_i, dut_wb_data_i};
    end
  end

  assign match_count_o  = match_q;
  assign fail_o         = fail_q;
  assign fail_cause_o   = cause_q;
  assign err_ref_rd_o   = err_ref_rd_q;
  assign err_dut_rd_o   = err_dut_rd_q;
  assign err_ref_data_o = err_ref_data_q;
  assign err_dut_data_o = err_dut_data_q;

endmodule
